// File: rtl/chroma_key_pipe.sv
// chroma_key_pipe
// Two-stage valid/ready pipeline that merges a camera pixel stream with a
// background image, replacing video by image where the key channel dominates.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_ready/in_sof   input handshake, in_sof marks first pixel of frame
//   video_r/g/b, img_r/g/b     camera and background pixel (DW bits each)
//   video_en, image_en         source enables, sampled with the pixel
//   th_key                     key threshold, latched on each accepted sof
//   out_valid/out_ready        output handshake
//   out_r/g/b, out_keyed       merged pixel and "replaced by image" flag
//   key_count                  keyed pixels counted in the last completed frame
//
// Optional build macro: SOFT_EDGE_EN -- pixels that fail the key only on the
// margin tests are output as the average of video and image.
module chroma_key_pipe #(
  parameter int DW           = 10,
  parameter int KEY_SEL      = 0,
  parameter int MARGIN_SHIFT = 2,
  parameter int FILL         = 2,
  parameter int CNT_W        = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [DW-1:0]    video_r,
  input  logic [DW-1:0]    video_g,
  input  logic [DW-1:0]    video_b,
  input  logic [DW-1:0]    img_r,
  input  logic [DW-1:0]    img_g,
  input  logic [DW-1:0]    img_b,
  input  logic             video_en,
  input  logic             image_en,
  input  logic [DW-1:0]    th_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_r,
  output logic [DW-1:0]    out_g,
  output logic [DW-1:0]    out_b,
  output logic             out_keyed,
  output logic [CNT_W-1:0] key_count
);

  localparam logic [DW-1:0] FILL_V = DW'(FILL);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef SOFT_EDGE_EN
  function automatic logic [DW-1:0] avg2(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return DW'(({1'b0, x} + {1'b0, y}) >> 1);
  endfunction
`endif

  logic             vld_p1, vld_p2;
  logic             adv, xfer_in, sof_xfer, cnt_inc;
  logic [DW-1:0]    th_active, th_cur, margin;
  logic [DW-1:0]    key_c, a_c, b_c;
  logic signed [DW:0] d_a, d_b;
  logic             key_gt, diff_pos, margin_ok, keyed_c;
  logic [CNT_W-1:0] run_cnt, run_next;

  logic [DW-1:0]    vid_r_p1, vid_g_p1, vid_b_p1, img_r_p1, img_g_p1, img_b_p1;
  logic             keyed_p1, ven_p1, ien_p1;
  logic [DW-1:0]    sel_r, sel_g, sel_b;
  logic             sel_k;

  // A bubble in S1 still needs an advance to move out; no squeezing.
  assign adv       = out_ready || !vld_p2;
  assign in_ready  = adv;
  assign out_valid = vld_p2;
  assign xfer_in   = in_valid && adv;
  assign sof_xfer  = xfer_in && in_sof;

  // The sof pixel already uses the newly requested threshold.
  assign th_cur = sof_xfer ? th_key : th_active;
  assign margin = th_cur >> MARGIN_SHIFT;

  always_comb begin
    a_c = video_r;
    if (KEY_SEL == 1) begin
      key_c = video_b;
      b_c   = video_g;
    end else begin
      key_c = video_g;
      b_c   = video_b;
    end
  end

  // Differences carry a sign bit so that A > K can never wrap into a key.
  assign d_a       = $signed({1'b0, key_c}) - $signed({1'b0, a_c});
  assign d_b       = $signed({1'b0, key_c}) - $signed({1'b0, b_c});
  assign key_gt    = key_c > th_cur;
  assign diff_pos  = !d_a[DW] && !d_b[DW];
  assign margin_ok = (d_a[DW-1:0] > margin) && (d_b[DW-1:0] > margin);
  assign keyed_c   = key_gt && diff_pos && margin_ok;

`ifdef SOFT_EDGE_EN
  logic edge_c, edge_p1;
  assign edge_c = key_gt && diff_pos && !margin_ok;
`endif

  // ---- S1: register pixel, key decision and enables ----
  always_ff @(posedge clk) begin
    if (xfer_in) begin
      vid_r_p1 <= video_r;
      vid_g_p1 <= video_g;
      vid_b_p1 <= video_b;
      img_r_p1 <= img_r;
      img_g_p1 <= img_g;
      img_b_p1 <= img_b;
      keyed_p1 <= keyed_c;
      ven_p1   <= video_en;
      ien_p1   <= image_en;
`ifdef SOFT_EDGE_EN
      edge_p1  <= edge_c;
`endif
    end
  end

  always_comb begin
    sel_r = vid_r_p1;
    sel_g = vid_g_p1;
    sel_b = vid_b_p1;
    sel_k = 1'b0;
    case ({ven_p1, ien_p1})
      2'b11: begin
        if (keyed_p1) begin
          sel_r = img_r_p1;
          sel_g = img_g_p1;
          sel_b = img_b_p1;
          sel_k = 1'b1;
        end
`ifdef SOFT_EDGE_EN
        else if (edge_p1) begin
          sel_r = avg2(vid_r_p1, img_r_p1);
          sel_g = avg2(vid_g_p1, img_g_p1);
          sel_b = avg2(vid_b_p1, img_b_p1);
        end
`endif
      end
      2'b10: ;
      2'b01: begin
        sel_r = img_r_p1;
        sel_g = img_g_p1;
        sel_b = img_b_p1;
      end
      default: begin
        sel_r = FILL_V;
        sel_g = FILL_V;
        sel_b = FILL_V;
      end
    endcase
  end

  // Increment lands in the same cycle as a sof so it is not lost.
  assign cnt_inc  = vld_p2 && out_ready && out_keyed;
  assign run_next = cnt_inc ? sat_inc(run_cnt) : run_cnt;

  // ---- S2: output registers, control and frame counter ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      th_active <= '0;
      run_cnt   <= '0;
      key_count <= '0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      out_keyed <= 1'b0;
    end else begin
      if (adv) begin
        vld_p1 <= in_valid;
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          out_r     <= sel_r;
          out_g     <= sel_g;
          out_b     <= sel_b;
          out_keyed <= sel_k;
        end
      end
      if (sof_xfer) begin
        th_active <= th_key;
        key_count <= run_next;
        run_cnt   <= '0;
      end else begin
        run_cnt <= run_next;
      end
    end
  end

endmodule

// File: tb/tb_chroma_key_pipe.sv
module tb_chroma_key_pipe;

  localparam int DW    = 10;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, in_sof;
  logic [DW-1:0]    video_r, video_g, video_b, img_r, img_g, img_b;
  logic             video_en, image_en;
  logic [DW-1:0]    th_key;
  logic             out_valid, out_ready;
  logic [DW-1:0]    out_r, out_g, out_b;
  logic             out_keyed;
  logic [CNT_W-1:0] key_count;

  int n_vec = 0;
  int n_err = 0;
  logic [30:0] exp_q[$];

  chroma_key_pipe #(.DW(DW), .KEY_SEL(0), .MARGIN_SHIFT(2), .FILL(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .video_r(video_r), .video_g(video_g), .video_b(video_b),
    .img_r(img_r), .img_g(img_g), .img_b(img_b),
    .video_en(video_en), .image_en(image_en), .th_key(th_key),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_keyed(out_keyed), .key_count(key_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Every transferred output is compared against the next expected pixel.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else chk("pix", {out_r, out_g, out_b, out_keyed}, exp_q.pop_front());
    end
  end

  task automatic send(input logic [9:0] vr, vg, vb, ir, ig, ib,
                      input logic ven, ien, sof, input logic [9:0] th,
                      input logic [9:0] er, eg, eb, input logic ek);
    bit ok;
    ok = 0;
    video_r = vr; video_g = vg; video_b = vb;
    img_r = ir; img_g = ig; img_b = ib;
    video_en = ven; image_en = ien; in_sof = sof; th_key = th;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (ok) exp_q.push_back({er, eg, eb, ek});
    else chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [30:0] snap;
    reset = 1'b1; in_valid = 0; in_sof = 0; out_ready = 1;
    video_r = 0; video_g = 0; video_b = 0; img_r = 0; img_g = 0; img_b = 0;
    video_en = 0; image_en = 0; th_key = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_keyed", out_keyed, 0);
    chk("rst_out_rgb", {out_r, out_g, out_b}, 0);
    chk("rst_key_count", key_count, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Frame A, th 400 (margin 100)
    send(100, 600, 100, 5, 6, 7, 1, 1, 1, 400, 5, 6, 7, 1);
    chk("lat_s1", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_s2", out_valid, 1);
    send(700, 600, 100, 5, 6, 7, 1, 1, 0, 400, 700, 600, 100, 0);
    send(100, 600, 100, 5, 6, 7, 0, 0, 0, 400, 2, 2, 2, 0);
    send(100, 600, 100, 5, 6, 7, 1, 0, 0, 400, 100, 600, 100, 0);
    send(100, 600, 100, 5, 6, 7, 0, 1, 0, 400, 5, 6, 7, 0);
    send(100, 400, 100, 5, 6, 7, 1, 1, 0, 400, 100, 400, 100, 0);
`ifdef SOFT_EDGE_EN
    send(500, 600, 100, 5, 6, 7, 1, 1, 0, 400, 252, 303, 53, 0);
    send(550, 600, 300, 100, 100, 100, 1, 1, 0, 400, 325, 350, 200, 0);
`else
    send(500, 600, 100, 5, 6, 7, 1, 1, 0, 400, 500, 600, 100, 0);
    send(550, 600, 300, 100, 100, 100, 1, 1, 0, 400, 550, 600, 300, 0);
`endif
    idle(3);

    // Backpressure: 4 pixels while the sink stalls
    fork
      begin
        send(100, 600, 100, 5, 6, 7, 1, 1, 0, 400, 5, 6, 7, 1);
        send(100, 700, 200, 11, 22, 33, 1, 1, 0, 400, 11, 22, 33, 1);
        send(700, 600, 100, 5, 6, 7, 1, 1, 0, 400, 700, 600, 100, 0);
        send(200, 650, 150, 1, 2, 3, 1, 1, 0, 400, 1, 2, 3, 1);
      end
      begin
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        snap = {out_r, out_g, out_b, out_keyed};
        chk("stall_out_valid", out_valid, 1);
        chk("stall_in_ready", in_ready, 0);
        repeat (3) begin
          @(negedge clk);
          chk("stall_hold", {out_r, out_g, out_b, out_keyed}, snap);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join

    // Mid-frame threshold change must not take effect yet
    send(100, 600, 100, 5, 6, 7, 1, 1, 0, 800, 5, 6, 7, 1);
    idle(4);

    // Frame B, th 800: previous frame had 5 keyed pixels
    send(100, 600, 100, 5, 6, 7, 1, 1, 1, 800, 100, 600, 100, 0);
    chk("key_count_A", key_count, 5);
    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 2) send(100, 600, 100, 5, 6, 7, 1, 1, 0, 800, 100, 600, 100, 0);
      else            send(100, 900, 100, 9, 9, 9, 1, 1, 0, 800, 9, 9, 9, 1);
    end
    idle(4);

    // Frame C, th 400: 10 keyed pixels saturate a 3-bit counter
    send(100, 600, 100, 5, 6, 7, 1, 1, 1, 400, 5, 6, 7, 1);
    chk("key_count_B", key_count, 6);
    for (int i = 0; i < 9; i++)
      send(100, 600, 100, 5, 6, 7, 1, 1, 0, 400, 5, 6, 7, 1);
    idle(4);
    send(700, 600, 100, 5, 6, 7, 1, 1, 1, 400, 700, 600, 100, 0);
    chk("key_count_sat", key_count, 7);
    idle(5);

    chk("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
